// File: rtl/ibex_instr_aligner.sv
// ============================================================================
// Module  : ibex_instr_aligner
// Purpose : Splits word-aligned fetch beats into 16/32-bit instructions,
//           including 32-bit instructions that straddle two fetch words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_instr_aligner #(
    parameter bit ResetAll = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_addr_i,
    input  logic        fetch_err_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_is_compressed_o,
    output logic        instr_err_o,
    output logic        instr_err_plus2_o
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] hw_q, hw_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        hold_load;

    always_comb begin
        state_d       = state_q;
        hold_load     = 1'b0;
        hw_d          = fetch_rdata_i[31:16];
        addr_d        = addr_q;
        err_d         = fetch_err_i;
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_rdata_o = fetch_rdata_i;
        instr_addr_o  = fetch_addr_i;
        instr_err_o   = 1'b0;
        instr_err_plus2_o = 1'b0;

        if (flush_i) begin
            fetch_ready_o = 1'b1;
            state_d       = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (fetch_valid_i) begin
                        if (fetch_addr_i[1]) begin
                            // Only the upper halfword is ours: buffer it first.
                            fetch_ready_o = 1'b1;
                            hold_load     = 1'b1;
                            addr_d        = fetch_addr_i;
                            state_d       = HALF;
                        end else begin
                            instr_valid_o = 1'b1;
                            instr_err_o   = fetch_err_i;
                            fetch_ready_o = instr_ready_i;
                            if (fetch_rdata_i[1:0] != 2'b11) begin
                                instr_rdata_o = {16'h0, fetch_rdata_i[15:0]};
                                if (instr_ready_i) begin
                                    hold_load = 1'b1;
                                    addr_d    = fetch_addr_i + 32'd2;
                                    state_d   = HALF;
                                end
                            end
                        end
                    end
                end
                HALF: begin
                    instr_addr_o = addr_q;
                    if (hw_q[1:0] != 2'b11) begin
                        instr_valid_o = 1'b1;
                        instr_rdata_o = {16'h0, hw_q};
                        instr_err_o   = err_q;
                        if (instr_ready_i) state_d = EMPTY;
                    end else if (err_q) begin
                        // Faulting first half: report now, no point waiting for the rest.
                        instr_valid_o = 1'b1;
                        instr_rdata_o = {fetch_rdata_i[15:0], hw_q};
                        instr_err_o   = 1'b1;
                        if (instr_ready_i) state_d = EMPTY;
                    end else begin
                        instr_valid_o     = fetch_valid_i;
                        instr_rdata_o     = {fetch_rdata_i[15:0], hw_q};
                        instr_err_o       = fetch_err_i;
                        instr_err_plus2_o = fetch_err_i;
                        fetch_ready_o     = instr_ready_i;
                        if (fetch_valid_i && instr_ready_i) begin
                            hold_load = 1'b1;
                            addr_d    = addr_q + 32'd4;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        if (!rst_ni) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
        end
    end

    assign instr_is_compressed_o = (instr_rdata_o[1:0] != 2'b11);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    generate
        if (ResetAll) begin : g_hold_reset
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    hw_q   <= 16'h0;
                    addr_q <= 32'h0;
                    err_q  <= 1'b0;
                end else if (hold_load) begin
                    hw_q   <= hw_d;
                    addr_q <= addr_d;
                    err_q  <= err_d;
                end
            end
        end else begin : g_hold_noreset
            always_ff @(posedge clk_i) begin
                if (hold_load) begin
                    hw_q   <= hw_d;
                    addr_q <= addr_d;
                    err_q  <= err_d;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ibex_instr_aligner.sv
// ============================================================================
// Module  : tb_ibex_instr_aligner
// Purpose : Directed and random checks of ibex_instr_aligner against a
//           halfword-queue reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibex_instr_aligner;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic [31:0] fetch_rdata_i = 32'h0;
    logic [31:0] fetch_addr_i = 32'h0;
    logic        fetch_err_i = 1'b0;
    logic        instr_ready_i = 1'b0;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        instr_is_compressed_o;
    logic        instr_err_o;
    logic        instr_err_plus2_o;

    ibex_instr_aligner dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_ready_o         (fetch_ready_o),
        .fetch_rdata_i         (fetch_rdata_i),
        .fetch_addr_i          (fetch_addr_i),
        .fetch_err_i           (fetch_err_i),
        .instr_valid_o         (instr_valid_o),
        .instr_ready_i         (instr_ready_i),
        .instr_rdata_o         (instr_rdata_o),
        .instr_addr_o          (instr_addr_o),
        .instr_is_compressed_o (instr_is_compressed_o),
        .instr_err_o           (instr_err_o),
        .instr_err_plus2_o     (instr_err_plus2_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] hw;
        logic [31:0] addr;
        logic        err;
        logic        beat;
    } hw_t;

    hw_t         held[$];
    int          checks = 0;
    int          fails = 0;
    bit          x_en = 1'b0;
    logic [31:0] x_rdata, x_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] data, input logic [31:0] addr,
                         input logic err, input logic rdy, input logic fl);
        flush_i       = fl;
        fetch_valid_i = fv;
        fetch_rdata_i = data;
        fetch_addr_i  = addr;
        fetch_err_i   = err;
        instr_ready_i = rdy;
    endtask

    // One clock: predict from the halfword queue, check, then retire halfwords.
    task automatic run_cycle(output bit consumed);
        hw_t         avail[$];
        hw_t         keep[$];
        hw_t         head;
        bit          e_valid, e_err, e_plus2, data_known, hs;
        logic [31:0] e_rdata, e_addr;
        int          n_used, n_held;

        avail = held;
        n_held = held.size();
        e_valid = 0; e_err = 0; e_plus2 = 0; data_known = 1; n_used = 0;
        e_rdata = 32'h0; e_addr = 32'h0;
        if (fetch_valid_i && !flush_i) begin
            if (!fetch_addr_i[1])
                avail.push_back('{hw: fetch_rdata_i[15:0], addr: {fetch_addr_i[31:2], 2'b00},
                                  err: fetch_err_i, beat: 1'b1});
            avail.push_back('{hw: fetch_rdata_i[31:16], addr: {fetch_addr_i[31:2], 2'b10},
                              err: fetch_err_i, beat: 1'b1});
        end
        // An instruction may start at a held halfword or at the low half of a beat.
        if (!flush_i && avail.size() > 0 && (n_held > 0 || !fetch_addr_i[1])) begin
            head = avail[0];
            e_addr = head.addr;
            if (head.hw[1:0] != 2'b11) begin
                e_valid = 1; e_rdata = {16'h0, head.hw}; e_err = head.err; n_used = 1;
            end else if (head.err && !head.beat) begin
                e_valid = 1; e_err = 1; n_used = 1; data_known = 0;
            end else if (avail.size() >= 2) begin
                e_valid = 1; e_rdata = {avail[1].hw, head.hw};
                e_err = head.err | avail[1].err;
                e_plus2 = !head.err && avail[1].err;
                n_used = 2;
            end
        end
        hs = e_valid && instr_ready_i;
        consumed = flush_i || (fetch_valid_i &&
                   ((n_held == 0 && fetch_addr_i[1]) || (hs && n_used > n_held)));

        @(negedge clk_i);
        chk("instr_valid", {31'b0, instr_valid_o}, {31'b0, e_valid});
        if (fetch_valid_i || flush_i || n_held == 0)
            chk("fetch_ready", {31'b0, fetch_ready_o}, {31'b0, consumed});
        if (e_valid) begin
            chk("instr_addr", instr_addr_o, e_addr);
            chk("instr_err", {31'b0, instr_err_o}, {31'b0, e_err});
            chk("instr_err_plus2", {31'b0, instr_err_plus2_o}, {31'b0, e_plus2});
            if (data_known) begin
                chk("instr_rdata", instr_rdata_o, e_rdata);
                chk("is_compressed", {31'b0, instr_is_compressed_o},
                    {31'b0, (e_rdata[1:0] != 2'b11)});
            end
        end
        if (x_en) begin
            chk("example_rdata", instr_rdata_o, x_rdata);
            chk("example_addr", instr_addr_o, x_addr);
            x_en = 1'b0;
        end

        @(posedge clk_i);
        if (flush_i) begin
            held.delete();
        end else begin
            for (int i = (hs ? n_used : 0); i < avail.size(); i++) begin
                if (!avail[i].beat || consumed) begin
                    head = avail[i];
                    head.beat = 1'b0;
                    keep.push_back(head);
                end
            end
            held = keep;
        end
        #1;
    endtask

    task automatic step(input logic fv, input logic [31:0] data, input logic [31:0] addr,
                        input logic err, input logic rdy, input logic fl);
        bit c;
        drive(fv, data, addr, err, rdy, fl);
        run_cycle(c);
    endtask

    task automatic expect_instr(input logic [31:0] rdata, input logic [31:0] addr);
        x_en = 1'b1; x_rdata = rdata; x_addr = addr;
    endtask

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(1, 0) == 1) w[1:0] = 2'b11;
        if ($urandom_range(1, 0) == 1) w[17:16] = 2'b11;
        return w;
    endfunction

    initial begin
        bit          c, pending;
        logic [31:0] fetch_pc, tgt, bdata;
        logic        berr;

        // Reset holds both handshake outputs low even with a beat on the bus.
        drive(1'b1, 32'h0001_0001, 32'h0000_0002, 1'b0, 1'b1, 1'b1);
        repeat (2) @(negedge clk_i);
        chk("reset_instr_valid", {31'b0, instr_valid_o}, 32'h0);
        chk("reset_fetch_ready", {31'b0, fetch_ready_o}, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // c.li then c.nop from one beat.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        expect_instr(32'h0000_4501, 32'h80);
        step(1'b1, 32'h0001_4501, 32'h80, 1'b0, 1'b1, 1'b0);
        expect_instr(32'h0000_0001, 32'h82);
        step(1'b0, 32'h0, 32'h84, 1'b0, 1'b1, 1'b0);

        // Compressed followed by a word-spanning 32-bit instruction.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        expect_instr(32'h0000_4505, 32'h80);
        step(1'b1, 32'h0513_4505, 32'h80, 1'b0, 1'b1, 1'b0);
        expect_instr(32'h0001_0513, 32'h82);
        step(1'b1, 32'h0000_0001, 32'h84, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h88, 1'b0, 1'b1, 1'b0);

        // Flush to an odd halfword target.
        step(1'b1, 32'hDEAD_BEEF, 32'h88, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h4505_0000, 32'h102, 1'b0, 1'b1, 1'b0);
        expect_instr(32'h0000_4505, 32'h102);
        step(1'b0, 32'h0, 32'h104, 1'b0, 1'b1, 1'b0);

        // Bus error on the second word of a spanning instruction.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h0003_0000, 32'hFE, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0000, 32'h100, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h104, 1'b0, 1'b1, 1'b0);

        // Decoder stall with a 32-bit instruction waiting.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            expect_instr(32'h1234_5603, 32'h200);
            step(1'b1, 32'h1234_5603, 32'h200, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 32'h1234_5603, 32'h200, 1'b0, 1'b1, 1'b0);

        // Address wrap across 2^32.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        expect_instr(32'h0000_0001, 32'hFFFF_FFFC);
        step(1'b1, 32'h0003_0001, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        expect_instr(32'h5678_0003, 32'hFFFF_FFFE);
        step(1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b0);
        expect_instr(32'h0000_1234, 32'h2);
        step(1'b0, 32'h0, 32'h4, 1'b0, 1'b1, 1'b0);

        // Reset while a halfword is held must leave nothing behind.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h0003_0000, 32'h102, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 32'h0001_0000, 32'h106, 1'b0, 1'b1, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("midreset_instr_valid", {31'b0, instr_valid_o}, 32'h0);
        chk("midreset_fetch_ready", {31'b0, fetch_ready_o}, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        held.delete();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Random stream with stalls, bubbles, errors and flushes.
        fetch_pc = 32'h1000;
        pending = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(24, 0) == 0) begin
                tgt = $urandom;
                if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF8 + {$urandom_range(3, 0), 1'b0};
                tgt[0] = 1'b0;
                drive($urandom_range(1, 0) == 1, gen_word(), fetch_pc, 1'b0,
                      $urandom_range(1, 0) == 1, 1'b1);
                run_cycle(c);
                fetch_pc = tgt;
                pending = 1'b0;
            end else begin
                if (!pending) begin
                    bdata = gen_word();
                    berr = ($urandom_range(9, 0) == 0);
                    pending = 1'b1;
                end
                drive($urandom_range(3, 0) != 0, bdata, fetch_pc, berr,
                      $urandom_range(3, 0) != 0, 1'b0);
                run_cycle(c);
                if (c) begin
                    fetch_pc = {fetch_pc[31:2], 2'b00} + 32'd4;
                    pending = 1'b0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
